// File: rtl/serial_add_ctrl_pkg.sv
// Shared types and constants for the nibble-serial wide adder controller.
package serial_add_ctrl_pkg;

    localparam int NIBBLE_W        = 4;
    localparam int NIBBLES_DEFAULT = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    // Nibble counter width; never narrower than one bit.
    function automatic int cnt_width(input int nibbles);
        return (nibbles > 1) ? $clog2(nibbles) : 1;
    endfunction

endpackage

// File: rtl/adder_4bit.sv
// Shared 4-bit ripple-carry slice; c[i] is the carry out of bit i.
module adder_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic [3:0] c
);

    always_comb begin : ripple
        logic carry;
        // NOTE: every output of a combinational block gets a value before any
        // branch or loop, so no path can leave it unassigned and infer a latch.
        s     = '0;
        c     = '0;
        carry = cin;
        for (int i = 0; i < 4; i++) begin
            s[i]  = a[i] ^ b[i] ^ carry;
            carry = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
            c[i]  = carry;
        end
    end

endmodule

// File: rtl/serial_add_ctrl.sv
// Sequences one adder_4bit slice over NIBBLES nibbles to form a wide sum,
// carry-out and signed overflow behind a start/busy/done handshake.
module serial_add_ctrl
    import serial_add_ctrl_pkg::*;
#(
    parameter int NIBBLES = NIBBLES_DEFAULT
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [NIBBLE_W*NIBBLES-1:0]   a,
    input  logic [NIBBLE_W*NIBBLES-1:0]   b,
    input  logic                          cin,
    output logic                          busy,
    output logic                          done,
    output logic [NIBBLE_W*NIBBLES-1:0]   sum,
    output logic                          cout,
    output logic                          ovf
);

    localparam int W     = NIBBLE_W * NIBBLES;
    localparam int CNT_W = cnt_width(NIBBLES);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NIBBLES - 1);

    state_t           state_q, state_d;
    logic [W-1:0]     a_q, a_d;
    logic [W-1:0]     b_q, b_d;
    logic [W-1:0]     acc_q, acc_d;
    logic [W-1:0]     sum_q, sum_d;
    logic             carry_q, carry_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic [NIBBLE_W-1:0] slice_s;
    logic [NIBBLE_W-1:0] slice_c;
    logic [W-1:0]        acc_shift;
    logic                load;
    logic                unused_low_carries;

    adder_4bit u_slice (
        .a   (a_q[NIBBLE_W-1:0]),
        .b   (b_q[NIBBLE_W-1:0]),
        .cin (carry_q),
        .s   (slice_s),
        .c   (slice_c)
    );

    // Only the top two slice carries matter for cout/ovf.
    assign unused_low_carries = ^slice_c[1:0];

    // Newest slice sum enters at the top, so nibble 0 lands at [3:0] last.
    assign acc_shift = {slice_s, acc_q[W-1:NIBBLE_W]};

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        load    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                a_d     = a_q >> NIBBLE_W;
                b_d     = b_q >> NIBBLE_W;
                acc_d   = acc_shift;
                carry_d = slice_c[3];
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    state_d = ST_DONE;
                    sum_d   = acc_shift;
                    cout_d  = slice_c[3];
                    ovf_d   = slice_c[3] ^ slice_c[2];
                end
            end
            ST_DONE: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (load) begin
            a_d     = a;
            b_d     = b;
            carry_d = cin;
            cnt_d   = '0;
            acc_d   = '0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // its pre-edge value regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy = (state_q == ST_RUN);
    assign done = (state_q == ST_DONE);
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl with NIBBLES = 2, 4 and 8 instances.
module tb_serial_add_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        start2, cin2, busy2, done2, cout2, ovf2;
    logic [7:0]  a2, b2, sum2;
    logic        start4, cin4, busy4, done4, cout4, ovf4;
    logic [15:0] a4, b4, sum4;
    logic        start8, cin8, busy8, done8, cout8, ovf8;
    logic [31:0] a8, b8, sum8;

    serial_add_ctrl #(.NIBBLES(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2), .cin(cin2),
        .busy(busy2), .done(done2), .sum(sum2), .cout(cout2), .ovf(ovf2)
    );
    serial_add_ctrl #(.NIBBLES(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .cin(cin4),
        .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .ovf(ovf4)
    );
    serial_add_ctrl #(.NIBBLES(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] last_sum  [0:8];
    logic        last_cout [0:8];
    logic        last_ovf  [0:8];

    task automatic clear_last();
        for (int i = 0; i <= 8; i++) begin
            last_sum[i]  = '0;
            last_cout[i] = 1'b0;
            last_ovf[i]  = 1'b0;
        end
    endtask

    task automatic set_in(input int n, input logic st, input logic [31:0] av,
                          input logic [31:0] bv, input logic ci);
        case (n)
            2:       begin start2 = st; a2 = av[7:0];  b2 = bv[7:0];  cin2 = ci; end
            4:       begin start4 = st; a4 = av[15:0]; b4 = bv[15:0]; cin4 = ci; end
            default: begin start8 = st; a8 = av;       b8 = bv;       cin8 = ci; end
        endcase
    endtask

    // {busy, done, cout, ovf, zero-extended sum}
    function automatic logic [35:0] get_out(input int n);
        case (n)
            2:       return {busy2, done2, cout2, ovf2, 24'd0, sum2};
            4:       return {busy4, done4, cout4, ovf4, 16'd0, sum4};
            default: return {busy8, done8, cout8, ovf8, sum8};
        endcase
    endfunction

    // One operation on instance n; poke>0 re-asserts start during RUN cycle poke.
    task automatic run_op(input int n, input logic [31:0] av, input logic [31:0] bv,
                          input logic ci, input logic [31:0] es, input logic ec,
                          input logic eo, input int poke, input bit rel, input string name);
        logic [35:0] o;
        int dones;
        @(negedge clk);
        set_in(n, 1'b1, av, bv, ci);
        if (rel) rst = 1'b0;
        @(posedge clk);
        #1;
        set_in(n, 1'b0, ~av, ~bv, ~ci);
        dones = 0;
        for (int k = 1; k <= n + 3; k++) begin
            @(negedge clk);
            if (poke > 0 && k == poke)     set_in(n, 1'b1, 32'hAAAA_AAAA, 32'h5555_5555, 1'b1);
            if (poke > 0 && k == poke + 1) set_in(n, 1'b0, 32'h0, 32'h0, 1'b0);
            o = get_out(n);
            if (o[34]) dones++;
            n_cmp++;
            if (o[35] !== (k <= n)) begin
                n_bad++;
                $display("FAIL %s busy cycle %0d: got %b want %b", name, k, o[35], (k <= n));
            end
            n_cmp++;
            if (o[34] !== (k == n + 1)) begin
                n_bad++;
                $display("FAIL %s done cycle %0d: got %b want %b", name, k, o[34], (k == n + 1));
            end
            if (k <= n) begin
                n_cmp++;
                if (o[33:0] !== {last_cout[n], last_ovf[n], last_sum[n]}) begin
                    n_bad++;
                    $display("FAIL %s hold cycle %0d: got %h want %h", name, k, o[33:0],
                             {last_cout[n], last_ovf[n], last_sum[n]});
                end
            end
            if (k == n + 1) begin
                n_cmp++;
                if (o[31:0] !== es) begin
                    n_bad++;
                    $display("FAIL %s sum: got %h want %h", name, o[31:0], es);
                end
                n_cmp++;
                if (o[33] !== ec) begin
                    n_bad++;
                    $display("FAIL %s cout: got %b want %b", name, o[33], ec);
                end
                n_cmp++;
                if (o[32] !== eo) begin
                    n_bad++;
                    $display("FAIL %s ovf: got %b want %b", name, o[32], eo);
                end
            end
        end
        n_cmp++;
        if (dones !== 1) begin
            n_bad++;
            $display("FAIL %s done_count: got %0d want 1", name, dones);
        end
        last_sum[n]  = es;
        last_cout[n] = ec;
        last_ovf[n]  = eo;
    endtask

    task automatic test_reset();
        int sizes [3];
        sizes = '{2, 4, 8};
        rst = 1'b1;
        clear_last();
        foreach (sizes[i]) set_in(sizes[i], 1'b1, 32'h1234_5678, 32'h8765_4321, 1'b1);
        repeat (3) @(negedge clk);
        foreach (sizes[i]) begin
            n_cmp++;
            if (get_out(sizes[i]) !== 36'd0) begin
                n_bad++;
                $display("FAIL reset_n%0d: got %h want 0", sizes[i], get_out(sizes[i]));
            end
        end
        foreach (sizes[i]) set_in(sizes[i], 1'b0, 32'h0, 32'h0, 1'b0);
        run_op(4, 32'h0003, 32'h0004, 1'b0, 32'h0007, 1'b0, 1'b0, 0, 1'b1, "first_start");
    endtask

    task automatic test_basic();
        run_op(4, 32'h1234, 32'h4321, 1'b0, 32'h5555, 1'b0, 1'b0, 0, 1'b0, "basic");
    endtask

    task automatic test_carry();
        run_op(4, 32'hFFFF, 32'h0000, 1'b1, 32'h0000, 1'b1, 1'b0, 0, 1'b0, "ripple");
        run_op(4, 32'h7FFF, 32'h0001, 1'b0, 32'h8000, 1'b0, 1'b1, 0, 1'b0, "overflow");
    endtask

    task automatic test_busy_protect();
        run_op(4, 32'h00FF, 32'h0001, 1'b0, 32'h0100, 1'b0, 1'b0, 2, 1'b0, "busy_protect");
    endtask

    task automatic test_back_to_back();
        logic [15:0] op_a [3];
        logic [15:0] op_b [3];
        logic        op_c [3];
        logic [15:0] ex_s [3];
        logic        ex_c [3];
        logic        ex_o [3];
        logic [35:0] o;
        int k, j;
        op_a = '{16'h8000, 16'h1111, 16'hFFFF};
        op_b = '{16'h8000, 16'h2222, 16'hFFFF};
        op_c = '{1'b0, 1'b1, 1'b0};
        ex_s = '{16'h0000, 16'h3334, 16'hFFFE};
        ex_c = '{1'b1, 1'b0, 1'b1};
        ex_o = '{1'b1, 1'b0, 1'b0};
        @(negedge clk);
        set_in(4, 1'b1, {16'd0, op_a[0]}, {16'd0, op_b[0]}, op_c[0]);
        for (int e = 0; e < 15; e++) begin
            @(posedge clk);
            #1;
            if (e % 5 == 0) begin
                if (e / 5 < 2)
                    set_in(4, 1'b1, {16'd0, op_a[e/5+1]}, {16'd0, op_b[e/5+1]}, op_c[e/5+1]);
                else
                    set_in(4, 1'b0, 32'h0, 32'h0, 1'b0);
            end
            @(negedge clk);
            k = e + 1;
            o = get_out(4);
            n_cmp++;
            if (o[35] !== (k % 5 != 0)) begin
                n_bad++;
                $display("FAIL b2b busy cycle %0d: got %b want %b", k, o[35], (k % 5 != 0));
            end
            n_cmp++;
            if (o[34] !== (k % 5 == 0)) begin
                n_bad++;
                $display("FAIL b2b done cycle %0d: got %b want %b", k, o[34], (k % 5 == 0));
            end
            if (k % 5 == 0) begin
                j = k / 5 - 1;
                n_cmp++;
                if (o[33:0] !== {ex_c[j], ex_o[j], 16'd0, ex_s[j]}) begin
                    n_bad++;
                    $display("FAIL b2b result %0d: got %h want %h", j, o[33:0],
                             {ex_c[j], ex_o[j], 16'd0, ex_s[j]});
                end
            end
        end
        last_sum[4]  = {16'd0, ex_s[2]};
        last_cout[4] = ex_c[2];
        last_ovf[4]  = ex_o[2];
    endtask

    task automatic test_reset_mid_op();
        @(negedge clk);
        set_in(4, 1'b1, 32'h0F0F, 32'h0101, 1'b0);
        @(posedge clk);
        #1;
        set_in(4, 1'b0, 32'h0, 32'h0, 1'b0);
        repeat (2) @(negedge clk);
        n_cmp++;
        if (busy4 !== 1'b1) begin
            n_bad++;
            $display("FAIL mid_busy: got %b want 1", busy4);
        end
        #2;
        rst = 1'b1;
        set_in(4, 1'b1, 32'h1111, 32'h1111, 1'b0);
        #1;
        n_cmp++;
        if (get_out(4) !== 36'd0) begin
            n_bad++;
            $display("FAIL mid_async: got %h want 0", get_out(4));
        end
        clear_last();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if (get_out(4) !== 36'd0) begin
                n_bad++;
                $display("FAIL mid_hold %0d: got %h want 0", i, get_out(4));
            end
        end
        set_in(4, 1'b0, 32'h0, 32'h0, 1'b0);
        run_op(4, 32'h0001, 32'h0001, 1'b0, 32'h0002, 1'b0, 1'b0, 0, 1'b1, "after_reset");
    endtask

    task automatic test_param_sweep();
        run_op(2, 32'h7F, 32'h01, 1'b0, 32'h80, 1'b0, 1'b1, 0, 1'b0, "n2_ovf");
        run_op(2, 32'hFF, 32'h01, 1'b0, 32'h00, 1'b1, 1'b0, 0, 1'b0, "n2_carry");
        run_op(2, 32'h3C, 32'h5A, 1'b1, 32'h97, 1'b0, 1'b1, 0, 1'b0, "n2_mixed");
        run_op(8, 32'h1234_5678, 32'h8765_4321, 1'b0, 32'h9999_9999, 1'b0, 1'b0, 0, 1'b0, "n8_basic");
        run_op(8, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 0, 1'b0, "n8_ripple");
        run_op(8, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1, 0, 1'b0, "n8_ovf");
        run_op(8, 32'hDEAD_BEEF, 32'h0123_4567, 1'b1, 32'hDFD1_0457, 1'b0, 1'b0, 0, 1'b0, "n8_mixed");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_carry();
        test_busy_protect();
        test_back_to_back();
        test_reset_mid_op();
        test_param_sweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/serial_add_ctrl.md
# serial_add_ctrl

Multi-cycle wide adder controller that sequences the team's 4-bit ripple-carry slice (`adder_4bit`) over one nibble per clock. It produces an N-nibble sum, carry-out and signed overflow. It sits between a requester issuing `start`/operands and the shared 4-bit adder datapath, and owns the operand shift registers, inter-nibble carry register, nibble counter and handshake FSM.

## Interface
- `NIBBLES`, default 4: number of 4-bit slices per operation; operand width W = 4*NIBBLES; legal range 2..8.
- `clk` input 1: single clock, rising-edge.
- `rst` input 1: reset, asynchronous, active-high.
- `start` input 1: request; sampled only when `busy`=0.
- `a` input W: operand A; captured on an accepted `start`.
- `b` input W: operand B; captured on an accepted `start`.
- `cin` input 1: carry-in to nibble 0; captured on an accepted `start`.
- `busy` output 1: high while in RUN.
- `done` output 1: one-cycle pulse when the result becomes valid.
- `sum` output W: result; holds its value until the next completion.
- `cout` output 1: carry out of the top nibble.
- `ovf` output 1: signed overflow, carry into the MSB XOR carry out of the MSB.

## Operation
- FSM states: IDLE, RUN, DONE. Encoding is free, but there must be no unreachable states; any illegal encoding returns to IDLE.
- IDLE to RUN when `start`=1:
  - load `a` and `b` into shift registers;
  - load `cin` into the carry register;
  - clear the nibble counter and the accumulator.
- RUN, each clock:
  - the slice adds the low nibble of the A register, the low nibble of the B register and the carry register;
  - the 4-bit slice sum shifts into the top of the accumulator, LSB-nibble first, so after NIBBLES shifts nibble 0 sits at bits [3:0];
  - the carry register takes slice `c[3]`;
  - A and B shift right by 4;
  - the counter increments.
- RUN to DONE on the clock that processes nibble NIBBLES-1. On that same edge:
  - `sum` takes the final accumulator value;
  - `cout` takes slice `c[3]`;
  - `ovf` takes `c[3]` XOR `c[2]`.
- DONE:
  - `done`=1 and `busy`=0;
  - `start`=1 goes to RUN with a fresh capture (back-to-back);
  - otherwise go to IDLE.
- `start` while `busy`=1 is ignored. There is no queueing, and the operands in flight are not disturbed.
- Arithmetic is unsigned modulo 2^W; `cout` is bit W of a+b+cin. `ovf` interprets the operands as two's complement.
- The `a`, `b` and `cin` inputs may change freely after the accept edge.

## Timing
- Reset (async assert, values held while `rst`=1): state IDLE; `busy`=0; `done`=0; `sum`=0; `cout`=0; `ovf`=0; internal registers 0.
- Latency, with the accept edge at edge k:
  - `busy`=1 for cycles k+1..k+NIBBLES;
  - outputs update at edge k+NIBBLES, and `done`=1 during the cycle that follows.
- Throughput: one operation per NIBBLES+1 cycles when `start` is asserted in every DONE cycle.
- `sum`, `cout` and `ovf` change only at the completion edge or on reset. They never show partial results.
- Reset during RUN:
  - the operation is abandoned;
  - outputs go to their reset values immediately;
  - no `done` pulse is generated for it.
- `start`=1 while `rst`=1 is ignored. The first `start` is accepted at the first edge after `rst` deasserts.

## Structure
- Shared package holds:
  - the FSM state type and encoding;
  - the constants `NIBBLE_W`=4 and the default NIBBLES;
  - a function or constant for the counter width, clog2(NIBBLES).
- One sub-module instance: the existing `adder_4bit` slice, used unmodified as the datapath. The controller supplies slice `a`, `b` and `cin` and consumes `s` and `c`.
- All state lives in the controller: the A/B shift registers, carry register, counter, accumulator and output registers.

## Test plan
- Basic sum, NIBBLES=4: a=0x1234, b=0x4321, cin=0 → `sum`=0x5555, `cout`=0, `ovf`=0; `done` pulses exactly 5 cycles after the accept edge; `busy` is high for 4 cycles.
- Full carry ripple: a=0xFFFF, b=0x0000, cin=1 → `sum`=0x0000, `cout`=1, `ovf`=0. Also a=0x7FFF, b=0x0001, cin=0 → `sum`=0x8000, `cout`=0, `ovf`=1.
- Busy protection: accept a=0x00FF, b=0x0001; assert `start` with a=0xAAAA during RUN → result 0x0100; exactly one `done` pulse.
- Back-to-back: `start` held high continuously with new operands in each DONE cycle → one `done` every 5 cycles, each result correct; no IDLE cycle in between.
- Reset mid-op: assert `rst` asynchronously 2 cycles into RUN → `busy`, `done`, `sum`, `cout` and `ovf` go to 0 at once; after release, a new operation 0x0001+0x0001 → 0x0002.
- Parameter sweep: NIBBLES=2 and 8 with random operands against a+b+cin reference; latency = NIBBLES+1 cycles.
